ex_mem_pipe_reg: RTL and testbench

- Parametrised EX/MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Captures EX-stage results and computes the registered branch target (PC+4 + word offset).
- Decodes the M control field into branch/mem_read/mem_write and produces the registered take_branch decision.
- Sits between the ALU stage and data memory; supports back-pressure from MEM and pipeline flush.

---
 rtl/ex_mem_pipe_reg_if.sv | 47 ++++
 rtl/ex_mem_pipe_reg.sv | 224 ++++++++++++++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_pipe_reg_if.sv
// EX/MEM pipeline register bus: the EX-side entry (valid/ready plus payload)
// and the MEM-side registered entry (valid/ready plus decoded payload).
// The register itself uses the slave modport; the surrounding pipeline uses master.
interface ex_mem_pipe_reg_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WB_W       = 2
);
  // EX side
  logic                  in_valid;
  logic                  in_ready;
  logic [XLEN-3:0]       pc_4;
  logic [XLEN-3:0]       imm;
  logic                  zero_in;
  logic [XLEN-1:0]       alu_result_in;
  logic [XLEN-1:0]       read_data2_in;
  logic [REG_ADDR_W-1:0] wr_dst_in;
  logic [WB_W-1:0]       wb_in;
  logic [2:0]            m_in;
  // MEM side
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-3:0]       branch_dst;
  logic                  zero;
  logic [XLEN-1:0]       alu_result;
  logic [XLEN-1:0]       read_data2;
  logic [REG_ADDR_W-1:0] wr_dst;
  logic [WB_W-1:0]       wb;
  logic                  branch;
  logic                  mem_read;
  logic                  mem_write;
  logic                  take_branch;

  modport master (
    output in_valid, pc_4, imm, zero_in, alu_result_in, read_data2_in,
           wr_dst_in, wb_in, m_in, out_ready,
    input  in_ready, out_valid, branch_dst, zero, alu_result, read_data2,
           wr_dst, wb, branch, mem_read, mem_write, take_branch
  );

  modport slave (
    input  in_valid, pc_4, imm, zero_in, alu_result_in, read_data2_in,
           wr_dst_in, wb_in, m_in, out_ready,
    output in_ready, out_valid, branch_dst, zero, alu_result, read_data2,
           wr_dst, wb, branch, mem_read, mem_write, take_branch
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready handshake and a 2-entry skid
// buffer (main register M drives the outputs, skid register S absorbs the one
// entry accepted while MEM stalls). Branch target pc_4+imm is computed at
// capture. Optional performance counters are built when EX_MEM_PERF_CNT_EN
// is defined; otherwise both counter ports are tied to zero.
module ex_mem_pipe_reg #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WB_W       = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  ex_mem_pipe_reg_if.slave  bus,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_bubble_cnt
);

  localparam int AW = XLEN - 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state_r, state_next_s;

  logic in_ready_r, out_valid_r;
  logic accept_s, release_s;
  logic load_m_in_s, load_s_s, move_s_s, clear_m_s;
  logic [AW-1:0] target_s;

  // skid register
  logic [AW-1:0]         s_dst_r;
  logic                  s_zero_r;
  logic [XLEN-1:0]       s_alu_r, s_rd2_r;
  logic [REG_ADDR_W-1:0] s_wr_dst_r;
  logic [WB_W-1:0]       s_wb_r;
  logic [2:0]            s_m_r;

  // main register
  logic [AW-1:0]         m_dst_r;
  logic                  m_zero_r;
  logic [XLEN-1:0]       m_alu_r, m_rd2_r;
  logic [REG_ADDR_W-1:0] m_wr_dst_r;
  logic [WB_W-1:0]       m_wb_r;
  logic                  m_branch_r, m_mem_read_r, m_mem_write_r, m_take_r;

  assign accept_s  = bus.in_valid & in_ready_r;
  assign release_s = out_valid_r & bus.out_ready;
  // Word-address branch target; wraps modulo 2^(XLEN-2) by construction.
  assign target_s  = bus.pc_4 + bus.imm;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_EMPTY;
    else     state_r <= state_next_s;
  end

  // Next-state logic; flush overrides every handshake event
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: state_next_s = accept_s ? ST_ONE : ST_EMPTY;
        ST_ONE: begin
          case ({accept_s, release_s})
            2'b01:   state_next_s = ST_EMPTY;
            2'b10:   state_next_s = ST_TWO;
            default: state_next_s = ST_ONE;
          endcase
        end
        ST_TWO:   state_next_s = release_s ? ST_ONE : ST_TWO;
        default:  state_next_s = ST_EMPTY;
      endcase
    end
  end

  // Datapath steering decoded from the current state and handshake events
  always_comb begin
    load_m_in_s = 1'b0;
    load_s_s    = 1'b0;
    move_s_s    = 1'b0;
    clear_m_s   = (state_next_s == ST_EMPTY);
    if (flush) begin
      load_m_in_s = 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: load_m_in_s = accept_s;
        ST_ONE: begin
          load_m_in_s = accept_s & release_s;
          load_s_s    = accept_s & ~release_s;
        end
        ST_TWO:   move_s_s = release_s;
        default:  load_m_in_s = 1'b0;
      endcase
    end
  end

  // Registered handshake outputs derived from the next state (no out_ready->in_ready path)
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s != ST_TWO);
      out_valid_r <= (state_next_s != ST_EMPTY);
    end
  end

  // Skid register captures the entry accepted while M is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s_dst_r    <= {AW{1'b0}};
      s_zero_r   <= 1'b0;
      s_alu_r    <= {XLEN{1'b0}};
      s_rd2_r    <= {XLEN{1'b0}};
      s_wr_dst_r <= {REG_ADDR_W{1'b0}};
      s_wb_r     <= {WB_W{1'b0}};
      s_m_r      <= 3'b000;
    end else if (load_s_s) begin
      s_dst_r    <= target_s;
      s_zero_r   <= bus.zero_in;
      s_alu_r    <= bus.alu_result_in;
      s_rd2_r    <= bus.read_data2_in;
      s_wr_dst_r <= bus.wr_dst_in;
      s_wb_r     <= bus.wb_in;
      s_m_r      <= bus.m_in;
    end
  end

  // Main data fields: loaded from EX or from S, otherwise hold last value
  always_ff @(posedge clk) begin
    if (rst) begin
      m_dst_r    <= {AW{1'b0}};
      m_zero_r   <= 1'b0;
      m_alu_r    <= {XLEN{1'b0}};
      m_rd2_r    <= {XLEN{1'b0}};
      m_wr_dst_r <= {REG_ADDR_W{1'b0}};
    end else if (load_m_in_s) begin
      m_dst_r    <= target_s;
      m_zero_r   <= bus.zero_in;
      m_alu_r    <= bus.alu_result_in;
      m_rd2_r    <= bus.read_data2_in;
      m_wr_dst_r <= bus.wr_dst_in;
    end else if (move_s_s) begin
      m_dst_r    <= s_dst_r;
      m_zero_r   <= s_zero_r;
      m_alu_r    <= s_alu_r;
      m_rd2_r    <= s_rd2_r;
      m_wr_dst_r <= s_wr_dst_r;
    end
  end

  // Main control fields: forced to zero whenever M becomes invalid
  always_ff @(posedge clk) begin
    if (rst) begin
      m_wb_r        <= {WB_W{1'b0}};
      m_branch_r    <= 1'b0;
      m_mem_read_r  <= 1'b0;
      m_mem_write_r <= 1'b0;
      m_take_r      <= 1'b0;
    end else if (load_m_in_s) begin
      m_wb_r        <= bus.wb_in;
      m_branch_r    <= bus.m_in[0];
      m_mem_read_r  <= bus.m_in[1];
      m_mem_write_r <= bus.m_in[2];
      m_take_r      <= bus.m_in[0] & bus.zero_in;
    end else if (move_s_s) begin
      m_wb_r        <= s_wb_r;
      m_branch_r    <= s_m_r[0];
      m_mem_read_r  <= s_m_r[1];
      m_mem_write_r <= s_m_r[2];
      m_take_r      <= s_m_r[0] & s_zero_r;
    end else if (clear_m_s) begin
      m_wb_r        <= {WB_W{1'b0}};
      m_branch_r    <= 1'b0;
      m_mem_read_r  <= 1'b0;
      m_mem_write_r <= 1'b0;
      m_take_r      <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.branch_dst  = m_dst_r;
  assign bus.zero        = m_zero_r;
  assign bus.alu_result  = m_alu_r;
  assign bus.read_data2  = m_rd2_r;
  assign bus.wr_dst      = m_wr_dst_r;
  assign bus.wb          = m_wb_r;
  assign bus.branch      = m_branch_r;
  assign bus.mem_read    = m_mem_read_r;
  assign bus.mem_write   = m_mem_write_r;
  assign bus.take_branch = m_take_r;

`ifdef EX_MEM_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r, bubble_cnt_r;

  // Saturating stall/bubble counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r  <= {CNT_W{1'b0}};
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (out_valid_r && !bus.out_ready && (stall_cnt_r != {CNT_W{1'b1}}))
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (!out_valid_r && (bubble_cnt_r != {CNT_W{1'b1}}))
        bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign perf_stall_cnt  = stall_cnt_r;
  assign perf_bubble_cnt = bubble_cnt_r;
`else
  assign perf_stall_cnt  = {CNT_W{1'b0}};
  assign perf_bubble_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed self-checking bench for ex_mem_pipe_reg (XLEN=32, CNT_W=4).
module tb_ex_mem_pipe_reg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WB_W       = 2;
  localparam int CNT_W      = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [CNT_W-1:0] perf_stall_cnt, perf_bubble_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  ex_mem_pipe_reg_if #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .WB_W(WB_W)) bus ();

  ex_mem_pipe_reg #(
    .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .WB_W(WB_W), .CNT_W(CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .bus             (bus),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [29:0] pc, input logic [29:0] im,
                       input logic [31:0] alu, input logic [2:0] m, input logic z,
                       input logic [1:0] wbv);
    bus.in_valid      = v;
    bus.pc_4          = pc;
    bus.imm           = im;
    bus.alu_result_in = alu;
    bus.read_data2_in = ~alu;
    bus.wr_dst_in     = alu[4:0];
    bus.m_in          = m;
    bus.zero_in       = z;
    bus.wb_in         = wbv;
  endtask

  task automatic check_ctrl_zero(input string tag);
    check_eq({tag, "_wb"},    {30'd0, bus.wb}, 32'd0);
    check_eq({tag, "_br"},    {31'd0, bus.branch}, 32'd0);
    check_eq({tag, "_mr"},    {31'd0, bus.mem_read}, 32'd0);
    check_eq({tag, "_mw"},    {31'd0, bus.mem_write}, 32'd0);
    check_eq({tag, "_take"},  {31'd0, bus.take_branch}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 30'h0, 30'h0, 32'h0, 3'b000, 1'b0, 2'b00);
    tick();
    tick();
    // reset state
    check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    check_eq("rst_dst",       {2'd0, bus.branch_dst}, 32'd0);
    check_eq("rst_alu",       bus.alu_result, 32'd0);
    check_ctrl_zero("rst");
    rst = 1'b0;

    // streaming with out_ready=1
    bus.out_ready = 1'b1;
    drive(1'b1, 30'h100, 30'h4, 32'h11, 3'b010, 1'b0, 2'b01);
    tick();
    check_eq("s1_valid", {31'd0, bus.out_valid}, 32'd1);
    check_eq("s1_dst",   {2'd0, bus.branch_dst}, 32'h104);
    check_eq("s1_alu",   bus.alu_result, 32'h11);
    check_eq("s1_rd2",   bus.read_data2, 32'hFFFF_FFEE);
    check_eq("s1_mr",    {31'd0, bus.mem_read}, 32'd1);
    check_eq("s1_wb",    {30'd0, bus.wb}, 32'd1);
    drive(1'b1, 30'h100, 30'h3FFF_FFFF, 32'h12, 3'b000, 1'b0, 2'b10);
    tick();
    check_eq("s2_valid", {31'd0, bus.out_valid}, 32'd1);
    check_eq("s2_dst",   {2'd0, bus.branch_dst}, 32'h0FF);
    check_eq("s2_ready", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b1, 30'h100, 30'h10, 32'h13, 3'b000, 1'b0, 2'b11);
    tick();
    check_eq("s3_valid", {31'd0, bus.out_valid}, 32'd1);
    check_eq("s3_dst",   {2'd0, bus.branch_dst}, 32'h110);
    check_eq("s3_wrdst", {27'd0, bus.wr_dst}, 32'h13);
    drive(1'b0, 30'h0, 30'h0, 32'h0, 3'b000, 1'b0, 2'b00);
    tick();
    check_eq("s4_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("s4_alu_hold", bus.alu_result, 32'h13);
    check_ctrl_zero("s4");

    // branch decision
    drive(1'b1, 30'h20, 30'h1, 32'h0, 3'b001, 1'b1, 2'b00);
    tick();
    check_eq("b1_take", {31'd0, bus.take_branch}, 32'd1);
    check_eq("b1_br",   {31'd0, bus.branch}, 32'd1);
    drive(1'b1, 30'h20, 30'h1, 32'h0, 3'b001, 1'b0, 2'b00);
    tick();
    check_eq("b2_take", {31'd0, bus.take_branch}, 32'd0);
    check_eq("b2_br",   {31'd0, bus.branch}, 32'd1);
    drive(1'b1, 30'h20, 30'h1, 32'h0, 3'b100, 1'b1, 2'b00);
    tick();
    check_eq("b3_mw",   {31'd0, bus.mem_write}, 32'd1);
    check_eq("b3_br",   {31'd0, bus.branch}, 32'd0);
    check_eq("b3_take", {31'd0, bus.take_branch}, 32'd0);
    drive(1'b0, 30'h0, 30'h0, 32'h0, 3'b000, 1'b0, 2'b00);
    tick();

    // back-pressure: A,B fill, C held off, then drain in order
    bus.out_ready = 1'b0;
    drive(1'b1, 30'h0, 30'h0, 32'hA, 3'b000, 1'b0, 2'b01);
    tick();
    check_eq("bp_a_alu",   bus.alu_result, 32'hA);
    check_eq("bp_a_ready", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b1, 30'h0, 30'h0, 32'hB, 3'b000, 1'b0, 2'b01);
    tick();
    check_eq("bp_b_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("bp_b_alu",   bus.alu_result, 32'hA);
    drive(1'b1, 30'h0, 30'h0, 32'hC, 3'b000, 1'b0, 2'b01);
    tick();
    check_eq("bp_c_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("bp_c_alu",   bus.alu_result, 32'hA);
    bus.out_ready = 1'b1;
    tick();
    check_eq("bp_d1_alu",   bus.alu_result, 32'hB);
    check_eq("bp_d1_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    check_eq("bp_d2_alu",   bus.alu_result, 32'hC);
    check_eq("bp_d2_valid", {31'd0, bus.out_valid}, 32'd1);
    drive(1'b0, 30'h0, 30'h0, 32'h0, 3'b000, 1'b0, 2'b00);
    tick();
    check_eq("bp_d3_valid", {31'd0, bus.out_valid}, 32'd0);

    // flush while full with a new entry presented
    bus.out_ready = 1'b0;
    drive(1'b1, 30'h0, 30'h0, 32'hD, 3'b011, 1'b1, 2'b11);
    tick();
    drive(1'b1, 30'h0, 30'h0, 32'hE, 3'b110, 1'b1, 2'b11);
    tick();
    check_eq("fl_pre_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("fl_pre_take",  {31'd0, bus.take_branch}, 32'd1);
    flush = 1'b1;
    drive(1'b1, 30'h0, 30'h0, 32'hF, 3'b111, 1'b1, 2'b11);
    tick();
    flush = 1'b0;
    check_eq("fl_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("fl_ready", {31'd0, bus.in_ready}, 32'd1);
    check_ctrl_zero("fl");
    bus.out_ready = 1'b1;
    drive(1'b0, 30'h0, 30'h0, 32'h0, 3'b000, 1'b0, 2'b00);
    tick();
    check_eq("fl_after_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check_eq("fl_after2_valid", {31'd0, bus.out_valid}, 32'd0);

    // wraparound target
    drive(1'b1, 30'h3FFF_FFFF, 30'h2, 32'h55, 3'b000, 1'b0, 2'b00);
    tick();
    check_eq("wrap_dst", {2'd0, bus.branch_dst}, 32'h1);

    // reset mid-stall
    bus.out_ready = 1'b0;
    drive(1'b1, 30'h8, 30'h8, 32'h66, 3'b011, 1'b1, 2'b10);
    tick();
    drive(1'b1, 30'h8, 30'h8, 32'h77, 3'b011, 1'b1, 2'b10);
    tick();
    check_eq("rs_pre_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, 30'h0, 30'h0, 32'h0, 3'b000, 1'b0, 2'b00);
    check_eq("rs_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rs_ready", {31'd0, bus.in_ready}, 32'd1);
    check_eq("rs_alu",   bus.alu_result, 32'd0);
    check_eq("rs_rd2",   bus.read_data2, 32'd0);
    check_eq("rs_dst",   {2'd0, bus.branch_dst}, 32'd0);
    check_ctrl_zero("rs");
    check_eq("rs_stall_cnt",  {28'd0, perf_stall_cnt}, 32'd0);
    check_eq("rs_bubble_cnt", {28'd0, perf_bubble_cnt}, 32'd0);
    tick();
    check_eq("rs_drain_valid", {31'd0, bus.out_valid}, 32'd0);

`ifdef EX_MEM_PERF_CNT_EN
    // counters: fresh reset, one bubble cycle with the push, then 20 stalls
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b1, 30'h0, 30'h0, 32'h1, 3'b000, 1'b0, 2'b00);
    tick();
    drive(1'b0, 30'h0, 30'h0, 32'h0, 3'b000, 1'b0, 2'b00);
    check_eq("pc_bubble1", {28'd0, perf_bubble_cnt}, 32'd1);
    check_eq("pc_stall0",  {28'd0, perf_stall_cnt}, 32'd0);
    for (int i = 0; i < 20; i++) tick();
    check_eq("pc_stall_sat", {28'd0, perf_stall_cnt}, 32'd15);
    check_eq("pc_bubble_hold", {28'd0, perf_bubble_cnt}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("pc_flush_stall",  {28'd0, perf_stall_cnt}, 32'd15);
    check_eq("pc_flush_bubble", {28'd0, perf_bubble_cnt}, 32'd1);
    tick();
    check_eq("pc_post_bubble", {28'd0, perf_bubble_cnt}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("pc_rst_stall",  {28'd0, perf_stall_cnt}, 32'd0);
    check_eq("pc_rst_bubble", {28'd0, perf_bubble_cnt}, 32'd0);
`else
    // counters are tied off: stall a while and confirm they stay zero
    bus.out_ready = 1'b0;
    drive(1'b1, 30'h0, 30'h0, 32'h1, 3'b000, 1'b0, 2'b00);
    tick();
    drive(1'b0, 30'h0, 30'h0, 32'h0, 3'b000, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) tick();
    check_eq("pc_off_stall",  {28'd0, perf_stall_cnt}, 32'd0);
    check_eq("pc_off_bubble", {28'd0, perf_bubble_cnt}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
